cpu_exec_wb_stage: RTL and testbench

Execute/write-back stage between instruction issue and `param_reg_file`. It accepts one ALU operation per cycle through a valid/ready handshake and drives the register file's two read ports combinationally. It computes a 74181-style function on the operands and registers the result. In the following cycle it drives the register file's write port. A read-after-write hazard against the in-flight write is resolved by a bypass path or by a one-cycle stall, selected at compile time.

---
 rtl/cpu_exec_wb_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_exec_wb_stage.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_wb_stage.sv
// ---------------------------------------------------------------------------
// cpu_exec_wb_stage
//
// Execute / write-back stage sitting between instruction issue and the
// register file. One ALU operation per cycle is accepted over a valid/ready
// handshake. The two register-file read ports are driven combinationally
// from the issue fields. A 74181-style function of the operands is computed
// and registered, and the registered result drives the register-file write
// port in the following cycle.
//
// A read-after-write hazard against the in-flight write is handled in one
// of two ways, chosen at compile time by the macro EXEC_BYPASS_EN:
//   defined   : the matching operand(s) take the in-flight write data and
//               the stage never stalls.
//   undefined : in_ready drops for one cycle so the write commits first,
//               then the operation is accepted with register-file data.
// ---------------------------------------------------------------------------
module cpu_exec_wb_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [3:0]            in_s,
    input  logic                  in_m,
    input  logic                  in_cin,
    input  logic                  in_wb,
    output logic [ADDR_WIDTH-1:0] rf_read_addr1,
    output logic [ADDR_WIDTH-1:0] rf_read_addr2,
    input  logic [DATA_WIDTH-1:0] rf_read_data1,
    input  logic [DATA_WIDTH-1:0] rf_read_data2,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  result_valid,
    output logic                  flag_cout,
    output logic                  flag_zero,
    output logic                  flag_aeqb
);

    // Occupancy of the write-back register.
    typedef enum logic [0:0] {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_t;

    wb_state_t state_r;
    wb_state_t state_next_s;

    logic                  accept_s;
    logic                  ready_s;
    logic                  wb_full_s;
    logic                  hit1_s;
    logic                  hit2_s;
    logic                  hazard_s;
    logic [DATA_WIDTH-1:0] op_a_s;
    logic [DATA_WIDTH-1:0] op_b_s;
    logic [DATA_WIDTH:0]   alu_s;
    logic [DATA_WIDTH-1:0] result_s;
    logic                  cout_s;
    logic                  zero_s;
    logic                  aeqb_s;

    // -----------------------------------------------------------------------
    // 74181 active-high function unit.
    //
    // The part is built from two per-bit terms:
    //   x = A | (B & S0) | (~B & S1)
    //   y = (A & ~B & S2) | (A & B & S3)
    // Arithmetic mode adds them with the carry-in (a term that is all ones
    // supplies the "minus 1" of the data sheet); logic mode is ~(x ^ y).
    // The returned vector is {carry_out, result}; carry_out is 0 in logic
    // mode.
    // -----------------------------------------------------------------------
    function automatic logic [DATA_WIDTH:0] alu_181(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [3:0]            s,
        input logic                  m,
        input logic                  cin
    );
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
        logic [DATA_WIDTH:0]   sum;
        x = a | (b & {DATA_WIDTH{s[0]}}) | (~b & {DATA_WIDTH{s[1]}});
        y = (a & ~b & {DATA_WIDTH{s[2]}}) | (a & b & {DATA_WIDTH{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {{DATA_WIDTH{1'b0}}, cin};
        if (m) begin
            alu_181 = {1'b0, ~(x ^ y)};
        end else begin
            alu_181 = sum;
        end
    endfunction

    // Read ports follow the issue fields directly.
    assign rf_read_addr1 = in_rs1;
    assign rf_read_addr2 = in_rs2;

    // Per-operand match against the write that is in flight this cycle.
    always_comb begin
        wb_full_s = (state_r == WB_FULL);
        hit1_s    = wb_full_s & rf_write_enable & (rf_write_addr == in_rs1);
        hit2_s    = wb_full_s & rf_write_enable & (rf_write_addr == in_rs2);
        hazard_s  = hit1_s | hit2_s;
    end

`ifdef EXEC_BYPASS_EN
    // Forward the in-flight write data into whichever operand(s) match.
    always_comb begin
        op_a_s = rf_read_data1;
        op_b_s = rf_read_data2;
        if (hit1_s) begin
            op_a_s = rf_write_data;
        end else begin
            op_a_s = rf_read_data1;
        end
        if (hit2_s) begin
            op_b_s = rf_write_data;
        end else begin
            op_b_s = rf_read_data2;
        end
    end

    // With forwarding in place the stage can always take a new operation.
    always_comb begin
        ready_s = 1'b1;
    end
`else
    // Operands come straight from the register file; hazards stall instead.
    always_comb begin
        op_a_s = rf_read_data1;
        op_b_s = rf_read_data2;
    end

    // Hold off issue for the one cycle in which the dependent write commits.
    always_comb begin
        ready_s = ~hazard_s;
    end
`endif

    // Evaluate the function and the flags on the selected operands.
    always_comb begin
        alu_s    = alu_181(op_a_s, op_b_s, in_s, in_m, in_cin);
        result_s = alu_s[DATA_WIDTH-1:0];
        cout_s   = alu_s[DATA_WIDTH];
        zero_s   = (result_s == {DATA_WIDTH{1'b0}});
        aeqb_s   = (op_a_s == op_b_s);
    end

    // FSM state register: write-back occupancy, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= WB_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: an accept fills the register, otherwise it drains.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WB_EMPTY: begin
                if (accept_s) begin
                    state_next_s = WB_FULL;
                end else begin
                    state_next_s = WB_EMPTY;
                end
            end
            WB_FULL: begin
                if (accept_s) begin
                    state_next_s = WB_FULL;
                end else begin
                    state_next_s = WB_EMPTY;
                end
            end
            default: begin
                state_next_s = WB_EMPTY;
            end
        endcase
    end

    // FSM outputs: handshake ready and the resulting accept strobe.
    always_comb begin
        in_ready = ready_s;
        accept_s = in_valid & ready_s;
    end

    // Write-back register: capture on accept, otherwise drop the strobes
    // and hold the last address, data and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= {ADDR_WIDTH{1'b0}};
            rf_write_data   <= {DATA_WIDTH{1'b0}};
            result_valid    <= 1'b0;
            flag_cout       <= 1'b0;
            flag_zero       <= 1'b0;
            flag_aeqb       <= 1'b0;
        end else if (accept_s) begin
            rf_write_enable <= in_wb;
            rf_write_addr   <= in_rd;
            rf_write_data   <= result_s;
            result_valid    <= 1'b1;
            flag_cout       <= cout_s;
            flag_zero       <= zero_s;
            flag_aeqb       <= aeqb_s;
        end else begin
            rf_write_enable <= 1'b0;
            result_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_exec_wb_stage.sv
// ---------------------------------------------------------------------------
// Testbench for cpu_exec_wb_stage.
//
// A behavioural register file sits on the DUT's ports. The reference model
// executes every accepted operation in program order against its own copy
// of the architectural registers, using the 74181 function table written
// out as plain arithmetic, and queues the expected write-back. A monitor
// thread pops and compares whenever result_valid is seen. Stall cycles are
// predicted from program order: a hazard exists only for an operation that
// directly follows a writing operation whose rd it reads.
// ---------------------------------------------------------------------------
module tb_cpu_exec_wb_stage;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [AW-1:0] in_rd;
    logic [3:0]    in_s;
    logic          in_m;
    logic          in_cin;
    logic          in_wb;
    logic [AW-1:0] rf_read_addr1;
    logic [AW-1:0] rf_read_addr2;
    logic [DW-1:0] rf_read_data1;
    logic [DW-1:0] rf_read_data2;
    logic          rf_write_enable;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;
    logic          result_valid;
    logic          flag_cout;
    logic          flag_zero;
    logic          flag_aeqb;

    cpu_exec_wb_stage #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rd           (in_rd),
        .in_s            (in_s),
        .in_m            (in_m),
        .in_cin          (in_cin),
        .in_wb           (in_wb),
        .rf_read_addr1   (rf_read_addr1),
        .rf_read_addr2   (rf_read_addr2),
        .rf_read_data1   (rf_read_data1),
        .rf_read_data2   (rf_read_data2),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .result_valid    (result_valid),
        .flag_cout       (flag_cout),
        .flag_zero       (flag_zero),
        .flag_aeqb       (flag_aeqb)
    );

    always #5 clk = ~clk;

    // Behavioural register file: asynchronous read, write at the clock edge.
    logic [DW-1:0] rf [NR];
    assign rf_read_data1 = rf[rf_read_addr1];
    assign rf_read_data2 = rf[rf_read_addr2];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          cout;
        logic          zero;
        logic          aeqb;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          hold;
    logic [DW-1:0] ref_regs [NR];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          prev_adj;
    logic          prev_wb;
    logic [AW-1:0] prev_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 74181 active-high functions, written straight from the data sheet.
    // Returns {carry_out, result}.
    function automatic logic [DW:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [3:0] s, input logic m, input logic cin);
        logic [DW-1:0] t1;
        logic [DW-1:0] t2;
        logic [DW-1:0] ones;
        logic [DW-1:0] f;
        ones = '1;
        if (m) begin
            case (s)
                4'd0:    f = ~a;
                4'd1:    f = ~(a | b);
                4'd2:    f = ~a & b;
                4'd3:    f = '0;
                4'd4:    f = ~(a & b);
                4'd5:    f = ~b;
                4'd6:    f = a ^ b;
                4'd7:    f = a & ~b;
                4'd8:    f = ~a | b;
                4'd9:    f = ~(a ^ b);
                4'd10:   f = b;
                4'd11:   f = a & b;
                4'd12:   f = ones;
                4'd13:   f = a | ~b;
                4'd14:   f = a | b;
                default: f = a;
            endcase
            return {1'b0, f};
        end
        case (s)
            4'd0:    begin t1 = a;      t2 = '0;     end
            4'd1:    begin t1 = a | b;  t2 = '0;     end
            4'd2:    begin t1 = a | ~b; t2 = '0;     end
            4'd3:    begin t1 = '0;     t2 = ones;   end
            4'd4:    begin t1 = a;      t2 = a & ~b; end
            4'd5:    begin t1 = a | b;  t2 = a & ~b; end
            4'd6:    begin t1 = a;      t2 = ~b;     end
            4'd7:    begin t1 = a & ~b; t2 = ones;   end
            4'd8:    begin t1 = a;      t2 = a & b;  end
            4'd9:    begin t1 = a;      t2 = b;      end
            4'd10:   begin t1 = a | ~b; t2 = a & b;  end
            4'd11:   begin t1 = a & b;  t2 = ones;   end
            4'd12:   begin t1 = a;      t2 = a;      end
            4'd13:   begin t1 = a | b;  t2 = a;      end
            4'd14:   begin t1 = a | ~b; t2 = a;      end
            default: begin t1 = a;      t2 = ones;   end
        endcase
        return {1'b0, t1} + {1'b0, t2} + {{DW{1'b0}}, cin};
    endfunction

    // Commit DUT writes into the behavioural register file.
    task automatic rf_writer();
        forever begin
            @(posedge clk);
            if (rf_write_enable) rf[rf_write_addr] = rf_write_data;
        end
    endtask

    // Scoreboard monitor: pop on every result_valid, otherwise check hold.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                hold = '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0};
            end else if (result_valid) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_result: result_valid with no expected op (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("wb_enable", 32'(rf_write_enable), 32'(e.we));
                    check("wb_addr",   32'(rf_write_addr),   32'(e.addr));
                    check("wb_data",   32'(rf_write_data),   32'(e.data));
                    check("flag_cout", 32'(flag_cout),       32'(e.cout));
                    check("flag_zero", 32'(flag_zero),       32'(e.zero));
                    check("flag_aeqb", 32'(flag_aeqb),       32'(e.aeqb));
                    hold = e;
                end
            end else begin
                check("idle_enable", 32'(rf_write_enable), 32'd0);
                check("hold_data",   32'(rf_write_data),   32'(hold.data));
                check("hold_flags",  32'({flag_cout, flag_zero, flag_aeqb}),
                      32'({hold.cout, hold.zero, hold.aeqb}));
            end
        end
    endtask

    // Offer one operation, wait (bounded) for acceptance, model it.
    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                         input logic [3:0] s, input logic m, input logic cin, input logic wb);
        int          stalls;
        int          exp_stalls;
        bit          done;
        logic        haz;
        logic [DW:0] r;
        exp_t        e;
        haz = prev_adj && prev_wb && (prev_rd == rs1 || prev_rd == rs2);
`ifdef EXEC_BYPASS_EN
        exp_stalls = 0;
`else
        exp_stalls = haz ? 1 : 0;
`endif
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_s = s; in_m = m; in_cin = cin; in_wb = wb;
        in_valid = 1'b1;
        stalls = 0;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else stalls++;
            @(posedge clk);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: op rd=%0d not accepted in 8 cycles", rd);
        end else begin
            r = ref_alu(ref_regs[rs1], ref_regs[rs2], s, m, cin);
            e.we   = wb;
            e.addr = rd;
            e.data = r[DW-1:0];
            e.cout = r[DW];
            e.zero = (r[DW-1:0] == 16'd0);
            e.aeqb = (ref_regs[rs1] == ref_regs[rs2]);
            sb_q.push_back(e);
            if (wb) ref_regs[rd] = r[DW-1:0];
            check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        end
        #1;
        in_valid = 1'b0;
        prev_adj = 1'b1;
        prev_wb  = wb;
        prev_rd  = rd;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        prev_adj = 1'b0;
    endtask

    // Preset a register in both the register file and the model (stage idle).
    task automatic poke(input int i, input logic [DW-1:0] v);
        rf[i] = v;
        ref_regs[i] = v;
    endtask

    initial begin
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [AW-1:0] rd;
        logic [DW-1:0] saved;

        reset = 1'b1;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_s = '0; in_m = 1'b0; in_cin = 1'b0; in_wb = 1'b0;
        prev_adj = 1'b0; prev_wb = 1'b0; prev_rd = '0;
        hold = '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < NR; i++) poke(i, 16'($urandom()));
        fork
            monitor();
            rf_writer();
        join_none

        #1;
        check("reset_ready",  32'(in_ready), 32'd1);
        check("reset_outputs", 32'({rf_write_enable, result_valid, flag_cout, flag_zero, flag_aeqb}), 32'd0);
        check("reset_data",   32'(rf_write_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Add: 5 + 3 = 8
        poke(1, 16'h0005); poke(2, 16'h0003);
        issue(3'd1, 3'd2, 3'd3, 4'b1001, 1'b0, 1'b0, 1'b1);
        // Subtract equal operands: zero, carry, aeqb
        issue(3'd2, 3'd2, 3'd5, 4'b0110, 1'b0, 1'b1, 1'b1);
        // Wrap-around: 0xFFFF + 0 + 1
        idle(2);
        poke(1, 16'hFFFF); poke(0, 16'h0000);
        issue(3'd1, 3'd0, 3'd4, 4'b1001, 1'b0, 1'b1, 1'b1);
        // Dependent pair r3 = r1 + r2, r4 = r3 + r3
        idle(2);
        poke(1, 16'h0005); poke(2, 16'h0003);
        issue(3'd1, 3'd2, 3'd3, 4'b1001, 1'b0, 1'b0, 1'b1);
        issue(3'd3, 3'd3, 3'd4, 4'b1001, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("r3_value", 32'(rf[3]), 32'h0008);
        check("r4_value", 32'(rf[4]), 32'h0010);
        // Logic AND, then the same with wb = 0 and a dependent read of its rd
        poke(1, 16'h00F0); poke(2, 16'h0FF0);
        issue(3'd1, 3'd2, 3'd6, 4'b1011, 1'b1, 1'b0, 1'b1);
        issue(3'd1, 3'd2, 3'd7, 4'b1011, 1'b1, 1'b1, 1'b0);
        issue(3'd7, 3'd7, 3'd5, 4'b1001, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("r6_value", 32'(rf[6]), 32'h00F0);

        // Reset during the write-back cycle drops the pending write
        saved = ref_regs[6];
        issue(3'd1, 3'd1, 3'd6, 4'b1001, 1'b0, 1'b0, 1'b1);
        ref_regs[6] = saved;
        reset = 1'b1;
        #1;
        check("reset_drops_we", 32'({rf_write_enable, result_valid}), 32'd0);
        check("reset_clears_data", 32'(rf_write_data), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        prev_adj = 1'b0;
        check("ready_after_reset", 32'(in_ready), 32'd1);
        check("rf_unchanged", 32'(rf[6]), 32'(saved));

        // Random traffic with frequent dependences and idle gaps
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            r1 = ($urandom_range(0, 2) == 0) ? prev_rd : 3'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 3) == 0) ? prev_rd : 3'($urandom_range(0, 7));
            rd = 3'($urandom_range(0, 7));
            issue(r1, r2, rd, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end
        idle(4);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < NR; i++) check("final_regfile", 32'(rf[i]), 32'(ref_regs[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
